ysyx_23060025_lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute-stage ALU: it takes the ALU `result` as the effective address (or as a pass-through writeback value for non-memory instructions), performs one memory transaction over a simple request/response bus, aligns and extends load data, and hands the writeback value to the WBU. Upstream and downstream use valid/ready handshakes; only one instruction is in flight at a time.

---
 rtl/ysyx_23060025_lsu_if.sv | 47 ++++
 rtl/ysyx_23060025_lsu.sv | 192 +++++++++++++++++++
 tb/tb_ysyx_23060025_lsu.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060025_lsu_if.sv
// Bundle of the LSU's three handshakes: EXU->LSU issue, LSU->memory bus, LSU->WBU writeback.
// slave = the LSU itself, master = the surrounding pipeline/bus environment.
interface ysyx_23060025_lsu_if #(
  parameter int DATA_LEN = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_alu_result;
  logic [DATA_LEN-1:0] in_store_data;
  logic                in_mem_en;
  logic [3:0]          in_mem_op;
  logic [4:0]          in_rd;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [DATA_LEN-1:0] mem_req_addr;
  logic                mem_req_wen;
  logic [DATA_LEN-1:0] mem_req_wdata;
  logic [3:0]          mem_req_wstrb;
  logic                mem_resp_valid;
  logic [DATA_LEN-1:0] mem_resp_rdata;
  logic                mem_resp_err;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_data;
  logic [4:0]          out_rd;
  logic                out_err;

  modport slave (
    input  in_valid, in_alu_result, in_store_data, in_mem_en, in_mem_op, in_rd,
    output in_ready,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
    output out_valid, out_data, out_rd, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_alu_result, in_store_data, in_mem_en, in_mem_op, in_rd,
    input  in_ready,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
    input  out_valid, out_data, out_rd, out_err,
    output out_ready
  );
endinterface

// File: rtl/ysyx_23060025_lsu.sv
// Single-outstanding load/store unit: one bus transaction per instruction, lane alignment and extension.
// Optional misalignment trap enabled by defining YSYX_23060025_LSU_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an instruction from EXU
// REQ   | bus request presented, waiting for mem_req_ready
// RESP  | waiting for mem_resp_valid
// DONE  | writeback presented, waiting for out_ready
module ysyx_23060025_lsu #(
  parameter int DATA_LEN = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_23060025_lsu_if.slave         bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_store;
  logic                r_unsigned;
  logic [1:0]          r_size;
  logic [1:0]          r_lane;
  logic [4:0]          r_rd;
  logic [DATA_LEN-1:0] r_req_addr;
  logic                r_req_wen;
  logic [DATA_LEN-1:0] r_req_wdata;
  logic [3:0]          r_req_wstrb;
  logic [DATA_LEN-1:0] r_out_data;
  logic [4:0]          r_out_rd;
  logic                r_out_err;

  logic                w_accept;
  logic                w_illegal;
  logic                w_misalign;
  logic                w_trap;
  logic                w_is_store;
  logic                w_resp_done;
  logic                w_in_ready;
  logic                w_req_valid;
  logic                w_out_valid;
  logic [DATA_LEN-1:0] w_wdata;
  logic [3:0]          w_wstrb;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_LEN-1:0] w_load_data;

  assign w_accept    = bus.in_valid & (r_state == S_IDLE);
  assign w_illegal   = (bus.in_mem_op[1:0] == 2'b11);
  assign w_is_store  = bus.in_mem_op[3];
  assign w_resp_done = (r_state == S_RESP) & bus.mem_resp_valid;

`ifdef YSYX_23060025_LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((bus.in_mem_op[1:0] == 2'b01) & bus.in_alu_result[0]) |
                      ((bus.in_mem_op[1:0] == 2'b10) & (|bus.in_alu_result[1:0]));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_trap = bus.in_mem_en & (w_illegal | w_misalign);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_req_valid = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          if (!bus.in_mem_en || w_trap) w_state_nxt = S_DONE;
          else                          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_req_valid = 1'b1;
        if (bus.mem_req_ready) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.mem_resp_valid) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Store data replicated across lanes so the strobe alone picks the target bytes.
  always_comb begin
    w_wdata = bus.in_store_data;
    w_wstrb = 4'b0000;
    case (bus.in_mem_op[1:0])
      2'b00: begin
        w_wdata = {4{bus.in_store_data[7:0]}};
        w_wstrb = 4'b0001 << bus.in_alu_result[1:0];
      end
      2'b01: begin
        w_wdata = {2{bus.in_store_data[15:0]}};
        w_wstrb = 4'b0011 << {bus.in_alu_result[1], 1'b0};
      end
      2'b10: begin
        w_wdata = bus.in_store_data;
        w_wstrb = 4'b1111;
      end
      default: begin
        w_wdata = bus.in_store_data;
        w_wstrb = 4'b0000;
      end
    endcase
  end

  assign w_byte = bus.mem_resp_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = r_lane[1] ? bus.mem_resp_rdata[31:16] : bus.mem_resp_rdata[15:0];

  always_comb begin
    w_load_data = bus.mem_resp_rdata;
    case (r_size)
      2'b00:   w_load_data = {{(DATA_LEN-8){~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{(DATA_LEN-16){~r_unsigned & w_half[15]}}, w_half};
      default: w_load_data = bus.mem_resp_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_store     <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'b00;
      r_lane      <= 2'b00;
      r_rd        <= 5'd0;
      r_req_addr  <= '0;
      r_req_wen   <= 1'b0;
      r_req_wdata <= '0;
      r_req_wstrb <= 4'b0000;
      r_out_data  <= '0;
      r_out_rd    <= 5'd0;
      r_out_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store     <= w_is_store;
        r_unsigned  <= bus.in_mem_op[2];
        r_size      <= bus.in_mem_op[1:0];
        r_lane      <= bus.in_alu_result[1:0];
        r_rd        <= bus.in_rd;
        r_req_addr  <= {bus.in_alu_result[DATA_LEN-1:2], 2'b00};
        r_req_wen   <= bus.in_mem_en & w_is_store & ~w_trap;
        r_req_wdata <= (bus.in_mem_en & w_is_store) ? w_wdata : '0;
        r_req_wstrb <= (bus.in_mem_en & w_is_store & ~w_trap) ? w_wstrb : 4'b0000;
        if (!bus.in_mem_en) begin
          r_out_data <= bus.in_alu_result;
          r_out_rd   <= bus.in_rd;
          r_out_err  <= 1'b0;
        end else if (w_trap) begin
          r_out_data <= '0;
          r_out_rd   <= 5'd0;
          r_out_err  <= 1'b1;
        end
      end
      if (w_resp_done) begin
        r_out_data <= r_store ? '0 : w_load_data;
        r_out_rd   <= r_store ? 5'd0 : r_rd;
        r_out_err  <= bus.mem_resp_err;
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.mem_req_valid = w_req_valid;
  assign bus.mem_req_addr  = r_req_addr;
  assign bus.mem_req_wen   = r_req_wen;
  assign bus.mem_req_wdata = r_req_wdata;
  assign bus.mem_req_wstrb = r_req_wstrb;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_data      = r_out_data;
  assign bus.out_rd        = r_out_rd;
  assign bus.out_err       = r_out_err;

endmodule

// File: tb/tb_ysyx_23060025_lsu.sv
// Directed + randomized bench for ysyx_23060025_lsu; expected results come from an arithmetic reference model.
module tb_ysyx_23060025_lsu;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ysyx_23060025_lsu_if #(.DATA_LEN(32)) bus();
  ysyx_23060025_lsu #(.DATA_LEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: effect of one instruction computed from byte-lane arithmetic.
  task automatic model(input logic mem_en, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd, input logic [31:0] rdata,
                       input logic rerr,
                       output logic e_bus, output logic [31:0] e_data, output logic [4:0] e_rd,
                       output logic e_rd_chk, output logic e_err,
                       output logic [3:0] e_wstrb, output logic [31:0] e_wdata);
    int unsigned size, shift, v;
    bit trap_mis;
    size = op[1:0];
    trap_mis = 0;
`ifdef YSYX_23060025_LSU_MISALIGN_TRAP_EN
    trap_mis = (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
`endif
    e_bus = 0; e_data = 0; e_rd = 0; e_rd_chk = 1; e_err = 0; e_wstrb = 0; e_wdata = 0;
    if (!mem_en) begin
      e_data = addr; e_rd = rd;
    end else if (size == 3 || trap_mis) begin
      e_err = 1; e_rd_chk = 0;
    end else begin
      e_bus = 1;
      e_err = rerr;
      if (op[3]) begin
        case (size)
          0: begin e_wstrb = 4'(1 << (addr % 4)); e_wdata = sdata[7:0] * 32'h0101_0101; end
          1: begin e_wstrb = 4'(3 << (addr & 2)); e_wdata = sdata[15:0] * 32'h0001_0001; end
          default: begin e_wstrb = 4'hF; e_wdata = sdata; end
        endcase
      end else begin
        e_rd = rd;
        shift = (size == 0) ? 8 * (addr % 4) : (size == 1) ? 8 * (addr & 2) : 0;
        v = rdata >> shift;
        if (size == 0) begin
          v = v & 32'hFF;
          if (!op[2] && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
          v = v & 32'hFFFF;
          if (!op[2] && v >= 32768) v = v + 32'hFFFF_0000;
        end
        e_data = v;
      end
    end
  endtask

  task automatic run_op(input logic mem_en, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd, input logic [31:0] rdata,
                        input logic rerr, input int req_dly, input int resp_dly, input int out_dly);
    logic e_bus, e_rd_chk, e_err;
    logic [31:0] e_data, e_wdata;
    logic [4:0] e_rd;
    logic [3:0] e_wstrb;
    model(mem_en, op, addr, sdata, rd, rdata, rerr, e_bus, e_data, e_rd, e_rd_chk, e_err, e_wstrb, e_wdata);
    chk("idle_in_ready", bus.in_ready, 1);
    bus.in_valid = 1; bus.in_mem_en = mem_en; bus.in_mem_op = op;
    bus.in_alu_result = addr; bus.in_store_data = sdata; bus.in_rd = rd;
    @(negedge clk);
    bus.in_valid = 0;
    bus.in_alu_result = $urandom; bus.in_store_data = $urandom;
    if (e_bus) begin
      chk("req_valid", bus.mem_req_valid, 1);
      chk("req_addr", bus.mem_req_addr, addr & 32'hFFFF_FFFC);
      chk("req_wen", bus.mem_req_wen, op[3]);
      chk("req_wstrb", bus.mem_req_wstrb, e_wstrb);
      if (op[3]) chk("req_wdata", bus.mem_req_wdata, e_wdata);
      for (int i = 0; i < req_dly; i++) begin
        @(negedge clk);
        chk("req_hold_valid", bus.mem_req_valid, 1);
        chk("req_hold_addr", bus.mem_req_addr, addr & 32'hFFFF_FFFC);
        chk("req_hold_wstrb", bus.mem_req_wstrb, e_wstrb);
        if (op[3]) chk("req_hold_wdata", bus.mem_req_wdata, e_wdata);
        chk("req_hold_in_ready", bus.in_ready, 0);
      end
      bus.mem_req_ready = 1;
      @(negedge clk);
      bus.mem_req_ready = 0;
      chk("req_dropped", bus.mem_req_valid, 0);
      for (int i = 0; i < resp_dly; i++) begin
        @(negedge clk);
        chk("resp_wait_out_valid", bus.out_valid, 0);
      end
      bus.mem_resp_valid = 1; bus.mem_resp_rdata = rdata; bus.mem_resp_err = rerr;
      @(negedge clk);
      bus.mem_resp_valid = 0; bus.mem_resp_rdata = $urandom; bus.mem_resp_err = 0;
    end else begin
      chk("no_req_valid", bus.mem_req_valid, 0);
    end
    chk("out_valid", bus.out_valid, 1);
    chk("out_data", bus.out_data, e_data);
    if (e_rd_chk) chk("out_rd", bus.out_rd, e_rd);
    chk("out_err", bus.out_err, e_err);
    for (int i = 0; i < out_dly; i++) begin
      @(negedge clk);
      chk("out_hold_valid", bus.out_valid, 1);
      chk("out_hold_data", bus.out_data, e_data);
      chk("out_hold_err", bus.out_err, e_err);
      chk("out_hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    chk("retired_out_valid", bus.out_valid, 0);
    chk("retired_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    rst = 1;
    bus.in_valid = 0; bus.in_alu_result = 0; bus.in_store_data = 0; bus.in_mem_en = 0;
    bus.in_mem_op = 0; bus.in_rd = 0; bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
    bus.mem_resp_rdata = 0; bus.mem_resp_err = 0; bus.out_ready = 0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_req_wen", bus.mem_req_wen, 0);
    chk("rst_req_addr", bus.mem_req_addr, 0);
    chk("rst_req_wdata", bus.mem_req_wdata, 0);
    chk("rst_req_wstrb", bus.mem_req_wstrb, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_rd", bus.out_rd, 0);
    chk("rst_out_err", bus.out_err, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);

    run_op(0, 4'b0000, 32'h1234_5678, 32'h0, 5'd5, 32'h0, 0, 0, 0, 0);
    run_op(1, 4'b0000, 32'h8000_0003, 32'h0, 5'd7, 32'h80FF_0011, 0, 0, 0, 0);
    run_op(1, 4'b0100, 32'h8000_0003, 32'h0, 5'd8, 32'h80FF_0011, 0, 0, 0, 0);
    run_op(1, 4'b1001, 32'h8000_0002, 32'hAAAA_BEEF, 5'd9, 32'h0, 0, 0, 0, 0);
    run_op(1, 4'b0001, 32'h8000_0102, 32'h0, 5'd10, 32'h9ABC_1234, 0, 3, 0, 2);
    run_op(1, 4'b0010, 32'h8000_0002, 32'h0, 5'd11, 32'hCAFE_F00D, 0, 0, 1, 0);
    run_op(1, 4'b1011, 32'h8000_0010, 32'h5555_5555, 5'd12, 32'h0, 0, 0, 0, 0);
    run_op(1, 4'b0010, 32'h8000_0020, 32'h0, 5'd13, 32'h1111_2222, 1, 1, 0, 1);

    // Abort a load while it waits for its response.
    run_op(0, 4'b0000, 32'hDEAD_BEEF, 32'h0, 5'd3, 32'h0, 0, 0, 0, 0);
    bus.in_valid = 1; bus.in_mem_en = 1; bus.in_mem_op = 4'b0010;
    bus.in_alu_result = 32'h8000_0040; bus.in_rd = 5'd4;
    @(negedge clk);
    bus.in_valid = 0;
    bus.mem_req_ready = 1;
    @(negedge clk);
    bus.mem_req_ready = 0;
    chk("abort_in_resp", bus.mem_req_valid, 0);
    rst = 1;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_data", bus.out_data, 0);
    chk("abort_out_rd", bus.out_rd, 0);
    chk("abort_req_addr", bus.mem_req_addr, 0);
    @(negedge clk);
    rst = 0;
    bus.mem_resp_valid = 1; bus.mem_resp_rdata = 32'h7777_7777;
    @(negedge clk);
    bus.mem_resp_valid = 0;
    @(negedge clk);
    chk("late_resp_out_valid", bus.out_valid, 0);
    chk("late_resp_in_ready", bus.in_ready, 1);
    run_op(0, 4'b0000, 32'h0BAD_F00D, 32'h0, 5'd6, 32'h0, 0, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      run_op(1'($urandom_range(0, 3) != 0), 4'($urandom), $urandom, $urandom, 5'($urandom),
             $urandom, 1'($urandom_range(0, 7) == 0),
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
